// File: rtl/median_frame_sequencer.sv
// Round-robin frame arbiter sharing one median_filter between two pixel sources.
// Optional watchdog abort: define MEDIAN_FRAME_SEQUENCER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no grant; arbitrate pending requests
// START  | one-cycle filter start pulse; clear pixel count and done_seen
// STREAM | forward the granted source's pixels until a full frame is accepted
// DRAIN  | frame sent; wait for filter done, then release the grant
module median_frame_sequencer #(
  parameter int IMAGE_LEN      = 1080,
  parameter int IMAGE_HEIGHT   = 720,
  parameter int PIXEL_W        = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               req_i,
  input  logic [1:0]               pix_valid_i,
  input  logic [2*3*PIXEL_W-1:0]   pix_data_i,
  output logic [1:0]               gnt_o,
  output logic                     flt_start_o,
  output logic                     flt_valid_o,
  output logic [3*PIXEL_W-1:0]     flt_pixel_o,
  input  logic                     flt_done_i,
  output logic [1:0]               frame_done_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int NPIX = IMAGE_LEN * IMAGE_HEIGHT;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int PW   = 3 * PIXEL_W;

  typedef enum logic [1:0] {S_IDLE, S_START, S_STREAM, S_DRAIN} state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_gnt;
  logic            r_last;
  logic [CW-1:0]   r_cnt;
  logic            r_done_seen;
  logic            r_flt_valid;
  logic [PW-1:0]   r_flt_pixel;
  logic [1:0]      r_frame_done;

  logic            w_src;
  logic [PW-1:0]   w_pix;
  logic            w_accept;
  logic            w_last_pix;
  logic            w_release;
  logic            w_pick;
  logic            w_timeout;

  assign w_src      = r_gnt[1];
  assign w_pix      = w_src ? pix_data_i[PW +: PW] : pix_data_i[0 +: PW];
  assign w_accept   = (r_state == S_STREAM) && pix_valid_i[w_src];
  assign w_last_pix = w_accept && (r_cnt == CW'(NPIX - 1));
  assign w_release  = (r_state == S_DRAIN) && (r_done_seen || flt_done_i);
  // On a tie the source that did not own the previous frame wins.
  assign w_pick     = (req_i == 2'b11) ? ~r_last : req_i[1];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (|req_i) w_next = S_START;
      S_START:  w_next = S_STREAM;
      S_STREAM: if (w_last_pix) w_next = S_DRAIN;
      S_DRAIN:  if (w_release) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt        <= 2'b00;
      r_last       <= 1'b1;
      r_cnt        <= '0;
      r_done_seen  <= 1'b0;
      r_flt_valid  <= 1'b0;
      r_flt_pixel  <= '0;
      r_frame_done <= 2'b00;
    end else begin
      r_flt_valid  <= 1'b0;
      r_frame_done <= 2'b00;
      case (r_state)
        S_IDLE:            if (|req_i) r_gnt <= w_pick ? 2'b10 : 2'b01;
        S_START: begin
          r_cnt       <= '0;
          r_done_seen <= flt_done_i;
        end
        S_STREAM, S_DRAIN: r_done_seen <= r_done_seen | flt_done_i;
        default: ;
      endcase
      if (w_accept) begin
        r_flt_valid <= 1'b1;
        r_flt_pixel <= w_pix;
        r_cnt       <= r_cnt + CW'(1);
      end
      if (w_release) begin
        r_frame_done <= r_gnt;
        r_last       <= w_src;
        r_gnt        <= 2'b00;
      end
      if (w_timeout) begin
        r_last <= w_src;
        r_gnt  <= 2'b00;
      end
    end
  end

`ifdef MEDIAN_FRAME_SEQUENCER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_wdog;
  logic          r_err;
  logic          w_wdog_run;

  assign w_wdog_run = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign w_timeout  = w_wdog_run && !w_accept && !flt_done_i && !w_release &&
                      (r_wdog == TW'(TIMEOUT_CYCLES - 1));

  // Counts only stalled cycles; any pixel or filter done restarts the window.
  always_ff @(posedge clk) begin
    if (rst || !w_wdog_run || w_accept || flt_done_i) r_wdog <= '0;
    else                                               r_wdog <= r_wdog + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_timeout;
  end

  assign err_o = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout        = 1'b0;
  assign err_o            = 1'b0;
`endif

  assign gnt_o        = r_gnt;
  assign flt_start_o  = (r_state == S_START);
  assign flt_valid_o  = r_flt_valid;
  assign flt_pixel_o  = r_flt_pixel;
  assign frame_done_o = r_frame_done;
  assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_median_frame_sequencer.sv
// Randomized self-checking bench for median_frame_sequencer (4x3 frames, timeout 16).
// Timeout scenario runs only when MEDIAN_FRAME_SEQUENCER_TIMEOUT_EN is defined.
module tb_median_frame_sequencer;

  localparam int IMAGE_LEN      = 4;
  localparam int IMAGE_HEIGHT   = 3;
  localparam int PIXEL_W        = 8;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int NPIX           = IMAGE_LEN * IMAGE_HEIGHT;
  localparam int PW             = 3 * PIXEL_W;

  logic            clk;
  logic            rst;
  logic [1:0]      req_i;
  logic [1:0]      pix_valid_i;
  logic [2*PW-1:0] pix_data_i;
  logic [1:0]      gnt_o;
  logic            flt_start_o;
  logic            flt_valid_o;
  logic [PW-1:0]   flt_pixel_o;
  logic            flt_done_i;
  logic [1:0]      frame_done_o;
  logic            busy_o;
  logic            err_o;

  int errors = 0;
  int checks = 0;
  int model_last = 1;
  int start_cnt = 0;
  logic [PW-1:0] got_q[$];
  logic [PW-1:0] exp_q[$];

  median_frame_sequencer #(
    .IMAGE_LEN(IMAGE_LEN), .IMAGE_HEIGHT(IMAGE_HEIGHT),
    .PIXEL_W(PIXEL_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .pix_valid_i(pix_valid_i),
    .pix_data_i(pix_data_i), .gnt_o(gnt_o), .flt_start_o(flt_start_o),
    .flt_valid_o(flt_valid_o), .flt_pixel_o(flt_pixel_o), .flt_done_i(flt_done_i),
    .frame_done_o(frame_done_o), .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (flt_valid_o) got_q.push_back(flt_pixel_o);
    if (flt_start_o) start_cnt++;
  end

  // Round-robin reference: a tie goes to whichever source did not own the last frame.
  function automatic int model_pick(input logic [1:0] req);
    if (req == 2'b11) return 1 - model_last;
    return req[1] ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_i = 2'b00; pix_valid_i = 2'b00; pix_data_i = '0; flt_done_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_last = 1;
  endtask

  task automatic do_frame(input logic [1:0] req, input bit hold, input int n_pix,
                          input bit seq_data, input bit gaps, input int done_at,
                          input int cross_n);
    int src, sent, cross_left;
    bit found, done_given, prev_valid;
    logic [1:0] exp_g;
    logic [PW-1:0] pix;
    src = model_pick(req);
    exp_g = (src == 1) ? 2'b10 : 2'b01;
    req_i = req;
    start_cnt = 0;
    got_q.delete();
    exp_q.delete();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (gnt_o != 2'b00) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL grant_wait gnt_o=%b required=%b", gnt_o, exp_g);
      req_i = 2'b00;
      return;
    end
    checks++;
    if (gnt_o !== exp_g) begin
      errors++; $display("FAIL grant gnt_o=%b required=%b", gnt_o, exp_g);
    end
    checks++;
    if (flt_start_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL start_pulse start=%b busy=%b required=1 1", flt_start_o, busy_o);
    end
    if (!hold) req_i = 2'b00;
    tick();
    sent = 0; cross_left = cross_n; done_given = 0;
    while (sent < n_pix || cross_left > 0) begin
      pix_valid_i = 2'b00;
      flt_done_i = 1'b0;
      if (done_at > 0 && sent == done_at && !done_given) begin
        flt_done_i = 1'b1;
        done_given = 1;
      end
      if (cross_left > 0 && $urandom_range(0, 1) == 1) begin
        pix_valid_i[1-src] = 1'b1;
        pix_data_i[(1-src)*PW +: PW] = 24'hFFFFFF;
        cross_left--;
      end
      if (sent < n_pix && !(gaps && $urandom_range(0, 3) == 0)) begin
        pix = seq_data ? PW'(sent + 1) : PW'($urandom);
        pix_valid_i[src] = 1'b1;
        pix_data_i[src*PW +: PW] = pix;
        if (sent < NPIX) exp_q.push_back(pix);
        sent++;
      end
      tick();
    end
    pix_valid_i = 2'b00;
    flt_done_i = 1'b0;
    if (!done_given) begin
      tick();
      tick();
      flt_done_i = 1'b1;
      tick();
      flt_done_i = 1'b0;
    end
    found = 0; prev_valid = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (frame_done_o != 2'b00) found = 1;
      else prev_valid = flt_valid_o;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL frame_done_wait frame_done_o=%b required=%b", frame_done_o, exp_g);
    end else begin
      checks++;
      if (frame_done_o !== exp_g || busy_o !== 1'b0 || gnt_o !== 2'b00) begin
        errors++;
        $display("FAIL frame_done done=%b busy=%b gnt=%b required=%b 0 00",
                 frame_done_o, busy_o, gnt_o, exp_g);
      end
      if (done_at > 0) begin
        checks++;
        if (prev_valid !== 1'b1) begin
          errors++; $display("FAIL early_done_latency prev_valid=%b required=1", prev_valid);
        end
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL pixel_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL pixel[%0d] got=%h required=%h", k, got_q[k], exp_q[k]);
      end
    end
    checks++;
    if (start_cnt != 1) begin
      errors++; $display("FAIL start_count got=%0d required=1", start_cnt);
    end
    model_last = src;
    if (!hold) begin
      @(negedge clk);
      checks++;
      if (frame_done_o !== 2'b00) begin
        errors++; $display("FAIL done_width frame_done_o=%b required=00", frame_done_o);
      end
    end
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({gnt_o, flt_start_o, flt_valid_o, flt_pixel_o, frame_done_o, busy_o, err_o} !== '0) begin
      errors++;
      $display("FAIL reset gnt=%b start=%b valid=%b pix=%h done=%b busy=%b err=%b required all 0",
               gnt_o, flt_start_o, flt_valid_o, flt_pixel_o, frame_done_o, busy_o, err_o);
    end
    tick();
  endtask

  task automatic test_single_frame();
    do_frame(2'b01, 1'b0, NPIX, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_frame(2'b11, 1'b1, NPIX, 1'b0, 1'b1, 0, 0);
    do_frame(2'b11, 1'b1, NPIX, 1'b0, 1'b1, 0, 0);
    do_frame(2'b11, 1'b1, NPIX, 1'b0, 1'b1, 0, 0);
    do_frame(2'b11, 1'b0, NPIX, 1'b0, 1'b1, 0, 0);
  endtask

  task automatic test_cross_traffic();
    do_frame(2'b01, 1'b0, NPIX, 1'b0, 1'b1, 0, 5);
  endtask

  task automatic test_early_done();
    do_frame(2'b10, 1'b0, NPIX, 1'b0, 1'b1, 9, 0);
  endtask

  task automatic test_extra_and_reset();
    bit found;
    do_frame(2'b01, 1'b0, NPIX + 3, 1'b0, 1'b1, 0, 0);
    req_i = 2'b10;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (gnt_o != 2'b00) found = 1;
    end
    checks++;
    if (gnt_o !== 2'b10) begin
      errors++; $display("FAIL partial_grant gnt_o=%b required=10", gnt_o);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      pix_valid_i = 2'b10;
      pix_data_i[PW +: PW] = PW'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({gnt_o, busy_o, flt_valid_o, flt_start_o, frame_done_o} !== '0) begin
      errors++;
      $display("FAIL midframe_reset gnt=%b busy=%b valid=%b start=%b done=%b required all 0",
               gnt_o, busy_o, flt_valid_o, flt_start_o, frame_done_o);
    end
    rst = 1'b0; pix_valid_i = 2'b00; req_i = 2'b00;
    model_last = 1;
    tick();
    do_frame(2'b11, 1'b0, NPIX, 1'b0, 1'b0, 0, 0);
  endtask

`ifdef MEDIAN_FRAME_SEQUENCER_TIMEOUT_EN
  task automatic test_timeout();
    bit found, saw_fd;
    apply_reset();
    req_i = 2'b01;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (gnt_o != 2'b00) found = 1;
    end
    checks++;
    if (gnt_o !== 2'b01) begin
      errors++; $display("FAIL timeout_grant gnt_o=%b required=01", gnt_o);
    end
    req_i = 2'b00;
    tick();
    for (int i = 0; i < 5; i++) begin
      pix_valid_i = 2'b01;
      pix_data_i[0 +: PW] = PW'($urandom);
      tick();
    end
    pix_valid_i = 2'b00;
    req_i = 2'b11;
    found = 0; saw_fd = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (frame_done_o != 2'b00) saw_fd = 1;
      if (err_o === 1'b1) found = 1;
    end
    checks++;
    if (!found || busy_o !== 1'b0 || gnt_o !== 2'b00 || saw_fd) begin
      errors++;
      $display("FAIL timeout_abort err_seen=%b busy=%b gnt=%b frame_done_seen=%b required 1 0 00 0",
               found, busy_o, gnt_o, saw_fd);
    end
    model_last = 0;
    @(negedge clk);
    checks++;
    if (gnt_o !== ((model_pick(2'b11) == 1) ? 2'b10 : 2'b01) || err_o !== 1'b0) begin
      errors++; $display("FAIL timeout_regrant gnt=%b err=%b required=10 0", gnt_o, err_o);
    end
    apply_reset();
  endtask
`endif

  initial begin
    rst = 1'b1; req_i = 2'b00; pix_valid_i = 2'b00; pix_data_i = '0; flt_done_i = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_cross_traffic();
    test_early_done();
    test_extra_and_reset();
`ifdef MEDIAN_FRAME_SEQUENCER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/median_frame_sequencer.md
Name: median_frame_sequencer

Overview:
- Shares one median_filter instance between two pixel sources (e.g. two camera channels) on a frame-by-frame basis.
- Round-robin arbitrates frame requests and pulses the filter's start.
- Forwards exactly one frame of the granted source's pixels, then waits for the filter's done before releasing the grant.
- Sits directly upstream of median_filter.

Parameters:
- IMAGE_LEN, 1080: pixels per row; must match the filter.
- IMAGE_HEIGHT, 720: rows per frame; must match the filter.
- PIXEL_W, 8: bits per colour channel.
- TIMEOUT_CYCLES, 65535: idle cycles tolerated in STREAM/DRAIN before abort (timeout build only).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_i  in  2  per-source frame request, level.
- pix_valid_i  in  2  per-source pixel valid.
- pix_data_i  in  2*3*PIXEL_W  per-source pixel; source n at bits [n*3*PIXEL_W +: 3*PIXEL_W]; within a pixel, {red,green,blue} with red in the MSBs.
- gnt_o  out  2  one-hot grant, held for the whole frame.
- flt_start_o  out  1  one-cycle start pulse to the filter.
- flt_valid_o  out  1  pixel valid to the filter.
- flt_pixel_o  out  3*PIXEL_W  pixel to the filter.
- flt_done_i  in  1  filter done pulse.
- frame_done_o  out  2  one-cycle pulse on the owning source's bit when its frame completes.
- busy_o  out  1  high in any state other than IDLE.
- err_o  out  1  one-cycle timeout pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; pixel count 0; done_seen 0; last_gnt=1, so source 0 wins first.
- States: IDLE, START, STREAM, DRAIN.
- IDLE, arbitration:
  - If any req_i bit is high, pick a source.
  - If both are high, pick the source that is not last_gnt.
  - Register gnt_o (one-hot) and go to START.
  - gnt_o is 0 in IDLE.
- START:
  - flt_start_o=1 for exactly this one cycle.
  - Clear pixel count and done_seen; go to STREAM.
- STREAM:
  - Each cycle pix_valid_i[g]=1 for granted source g: register flt_pixel_o<=that source's pixel and flt_valid_o<=1 (1-cycle latency); increment count.
  - Otherwise flt_valid_o<=0.
  - The non-granted source's valid and data are ignored and dropped; no backpressure exists.
  - When the accepted pixel makes count = IMAGE_LEN*IMAGE_HEIGHT, go to DRAIN. Further pixels from g are dropped.
  - Count width: $clog2(IMAGE_LEN*IMAGE_HEIGHT+1).
- done_seen: flt_done_i is legal before the last pixel. Latch it sticky in START, STREAM and DRAIN.
- DRAIN:
  - flt_valid_o=0.
  - When done_seen or flt_done_i is high: pulse frame_done_o[g], set last_gnt=g, clear gnt_o, go to IDLE.
  - Minimum frame turnaround is one IDLE cycle between frames.
- Mid-frame request changes: a req_i drop during a frame does not abort it. A req_i held high after frame_done re-requests a new frame.
- flt_done_i in IDLE: ignored.
- Reset mid-frame: everything returns to reset values immediately at the next edge.

Optional Feature:
- Macro: MEDIAN_FRAME_SEQUENCER_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in STREAM and DRAIN.
  - It clears on entry to START, on each accepted pixel and on flt_done_i.
  - When it reaches TIMEOUT_CYCLES: pulse err_o, clear gnt_o, return to IDLE without frame_done_o. last_gnt updates to g, so the other source gets the next grant.
- Undefined: err_o is tied 0, no watchdog logic exists, and the block waits indefinitely.

Test Plan:
(all tests use IMAGE_LEN=4, IMAGE_HEIGHT=3, TIMEOUT_CYCLES=16)
- Single frame:
  - Stimulus: req_i=01; feed 12 pixels 0x000001..0x00000C on source 0; flt_done_i 3 cycles after the last pixel.
  - Required: gnt_o=01, then one flt_start_o pulse; flt_valid_o high 12 times with data matching the inputs one cycle late; frame_done_o=01 pulse; busy_o back to 0.
- Simultaneous requests:
  - Stimulus: req_i=11 held.
  - Required: grants in order source 0, 1, 0, 1; each frame_done_o pulse on the matching bit.
- Cross-traffic:
  - Stimulus: source 0 granted; source 1 drives 5 valid pixels 0xFFFFFF during the frame.
  - Required: none of them appears on flt_pixel_o; exactly 12 flt_valid_o pulses.
- Early done:
  - Stimulus: flt_done_i pulses after pixel 9; then pixels 10-12 arrive.
  - Required: all 12 pixels forwarded; frame_done_o pulses one cycle after DRAIN is entered; no hang.
- Extra pixels and reset:
  - Stimulus: 15 pixels sent; then rst asserted mid-STREAM of the next frame.
  - Required: only 12 forwarded; after reset gnt_o=0, busy_o=0, flt_valid_o=0, and source 0 wins the next 11 request.
- Timeout (macro defined):
  - Stimulus: feed 5 pixels, then stall 16 cycles.
  - Required: err_o pulse, no frame_done_o, IDLE; a pending req_i=11 is then granted to source 1.
